pipe_ctrl: RTL

Central stall/flush sequencer for the 5-stage RV32 pipeline (IF, ID, EX, MEM, WB). It merges four inputs: data-hazard bubble requests from hazard detection, EX-stage redirects, MEM-stage data-memory wait, and IF-stage fetch wait. From these it drives the PC and pipeline-register write enables plus the bubble-insert (flush) controls. A counter FSM owns multi-cycle bubbles, so requesters only pulse a request with a bubble count. Saturating performance counters record stall and flush activity.

---
 rtl/pipe_ctrl_pkg.sv | 40 ++++
 rtl/pipe_ctrl_sat_counter.sv | 32 +++
 rtl/pipe_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states,
// pipeline control bundle, flush NOP and the legacy bubble-count codes.
package pipe_ctrl_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_RUN      = 2'd0;
    localparam logic [ST_W-1:0] ST_HZ_STALL = 2'd1;
    localparam logic [ST_W-1:0] ST_MEM_WAIT = 2'd2;

    // Instruction the pipeline registers load when flushed (addi x0, x0, 0).
    typedef enum logic [31:0] {
        NOP_INSN = 32'h0000_0013
    } nop_insn_e;

    // Legacy bubble-count codes; numerically identical to hz_cycles.
    typedef enum logic [1:0] {
        PIP_NOSTOP = 2'd0,
        PIP_1STOP  = 2'd1,
        PIP_2STOP  = 2'd2,
        PIP_3STOP  = 2'd3
    } pip_stop_e;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic exmem_we;
        logic memwb_we;
        logic ifid_flush;
        logic idex_flush;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_RUN        = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam pipe_ctl_t CTL_FREEZE     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam pipe_ctl_t CTL_BUBBLE     = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam pipe_ctl_t CTL_REDIRECT   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam pipe_ctl_t CTL_FETCH_WAIT = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Stick at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges memory wait, EX
// redirect, hazard bubbles and fetch wait into stage enables and flushes.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned HZ_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hz_req,
    input  logic [HZ_W-1:0]  hz_cycles,
    input  logic             br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             stall_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    logic [ST_W-1:0] state_q, state_d;
    logic [ST_W-1:0] saved_q, saved_d;
    logic [HZ_W-1:0] cnt_q, cnt_d;
    logic [ST_W-1:0] eff_state;
    pipe_ctl_t       ctl;
    logic            redirect;
    logic            hz_new;

    assign hz_new = hz_req && (hz_cycles != HZ_W'(PIP_NOSTOP));

    // Next-state and zero-latency outputs; a released memory wait replays the saved state.
    always_comb begin
        eff_state = state_q;
        if ((state_q == ST_MEM_WAIT) && dmem_ready) begin
            eff_state = saved_q;
        end
        state_d  = eff_state;
        saved_d  = saved_q;
        cnt_d    = cnt_q;
        ctl      = CTL_RUN;
        redirect = 1'b0;

        if ((state_q == ST_MEM_WAIT) && !dmem_ready) begin
            ctl = CTL_FREEZE;
        end else if ((state_q != ST_MEM_WAIT) && dmem_req && !dmem_ready) begin
            ctl     = CTL_FREEZE;
            saved_d = state_q;
            state_d = ST_MEM_WAIT;
        end else if (br_taken) begin
            ctl      = CTL_REDIRECT;
            redirect = 1'b1;
            cnt_d    = '0;
            state_d  = ST_RUN;
        end else if (eff_state == ST_HZ_STALL) begin
            ctl = CTL_BUBBLE;
            if (cnt_q <= HZ_W'(PIP_1STOP)) begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end else begin
                cnt_d   = cnt_q - HZ_W'(1);
                state_d = ST_HZ_STALL;
            end
        end else if (hz_new) begin
            ctl     = CTL_BUBBLE;
            cnt_d   = hz_cycles - HZ_W'(1);
            state_d = (hz_cycles > HZ_W'(PIP_1STOP)) ? ST_HZ_STALL : ST_RUN;
        end else if (!imem_ready) begin
            ctl = CTL_FETCH_WAIT;
        end

        if (!rst_n) begin
            ctl      = CTL_FREEZE;
            redirect = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            saved_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_we      = ctl.pc_we;
    assign ifid_we    = ctl.ifid_we;
    assign idex_we    = ctl.idex_we;
    assign exmem_we   = ctl.exmem_we;
    assign memwb_we   = ctl.memwb_we;
    assign ifid_flush = ctl.ifid_flush;
    assign idex_flush = ctl.idex_flush;
    assign stall_busy = rst_n && (state_q != ST_RUN);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!ctl.pc_we),
        .q     (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect),
        .q     (flush_events)
    );

endmodule
